// File: rtl/calc_controller.sv
// Switch-entry calculator sequencer: debounced buttons drive add/sub/clear on an
// 18-bit accumulator, followed by an 18-cycle shift-and-add-3 BCD conversion.

module calc_btn_db #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          db, db_d;
  logic [CW-1:0] cnt;

  // Reset to the released level so a button held through reset must re-debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      db   <= 1'b1;
      db_d <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], btn_raw};
      db_d <= db;
      if (sync[1] == db)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign press = db_d & ~db;
endmodule

module calc_controller #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  num,
  input  logic [2:0]  btn,
  output logic [17:0] bin_18,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_4,
  output logic [3:0]  digit_5,
  output logic [3:0]  digit_6,
  output logic        busy,
  output logic        ovf,
  output logic        unf
);
  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;
  typedef enum logic [1:0] {CMD_ADD, CMD_SUB, CMD_CLR} cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd;
  logic [2:0]  press;
  logic [17:0] shift_reg;
  logic [23:0] bcd;
  logic [4:0]  bit_cnt;
  logic [18:0] sum;
  logic [17:0] exec_bin;
  logic        exec_ovf, exec_unf;
  logic [41:0] conv_nxt;

  calc_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn),
    .press   (press)
  );

  function automatic logic [23:0] add3(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    sum      = {1'b0, bin_18} + {9'd0, num};
    exec_bin = bin_18;
    exec_ovf = 1'b0;
    exec_unf = 1'b0;
    case (cmd)
      CMD_ADD: begin
        exec_ovf = sum[18];
        exec_bin = sum[18] ? 18'h3ffff : sum[17:0];
      end
      CMD_SUB: begin
        exec_unf = ({8'd0, num} > bin_18);
        exec_bin = exec_unf ? 18'd0 : bin_18 - {8'd0, num};
      end
      default: exec_bin = 18'd0;
    endcase
    conv_nxt = {add3(bcd), shift_reg} << 1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|press) state_nxt = EXEC;
      EXEC: state_nxt = CONV;
      CONV: if (bit_cnt == 5'd17) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd       <= CMD_ADD;
      bin_18    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      {digit_6, digit_5, digit_4, digit_3, digit_2, digit_1} <= '0;
    end else begin
      case (state)
        IDLE: if (|press) cmd <= press[2] ? CMD_CLR : (press[1] ? CMD_SUB : CMD_ADD);
        EXEC: begin
          bin_18    <= exec_bin;
          ovf       <= exec_ovf;
          unf       <= exec_unf;
          shift_reg <= exec_bin;
          bcd       <= '0;
          bit_cnt   <= '0;
        end
        CONV: begin
          {bcd, shift_reg} <= conv_nxt;
          bit_cnt          <= bit_cnt + 5'd1;
        end
        DONE: {digit_6, digit_5, digit_4, digit_3, digit_2, digit_1} <= bcd;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with a short debounce window.

module tb_calc_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  num;
  logic [2:0]  btn;
  logic [17:0] bin_18;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4, digit_5, digit_6;
  logic        busy, ovf, unf;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_bin;

  calc_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .num(num), .btn(btn), .bin_18(bin_18),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_4(digit_4), .digit_5(digit_5), .digit_6(digit_6),
    .busy(busy), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] digits();
    return {digit_6, digit_5, digit_4, digit_3, digit_2, digit_1};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Press the buttons in mask, follow the command to completion, check results.
  task automatic press(input string tag, input logic [2:0] mask, input int eb,
                       input logic eo, input logic eu);
    int c;
    @(negedge clk);
    btn = ~mask;
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " start"}, int'(busy), 1);
    c = 0;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
    if (c != 0) chk({tag, " busy_len"}, c, 20);
    chk({tag, " bin"}, int'(bin_18), eb);
    chk({tag, " ovf"}, int'(ovf), int'(eo));
    chk({tag, " unf"}, int'(unf), int'(eu));
    chk({tag, " digits"}, int'(digits()), int'(to_bcd(eb)));
    btn = 3'b111;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int c, seen;
    rst = 1'b1; btn = 3'b111; num = '0;
    #1;
    chk("rst bin", int'(bin_18), 0);
    chk("rst digits", int'(digits()), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst flags", int'({ovf, unf}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("idle busy", seen, 0);
    chk("idle bin", int'(bin_18), 0);
    chk("idle digits", int'(digits()), 0);

    num = 10'd1023;
    press("add1", 3'b001, 1023, 1'b0, 1'b0);
    chk("add1 digits hex", int'(digits()), 24'h001023);
    press("add2", 3'b001, 2046, 1'b0, 1'b0);
    chk("add2 digits hex", int'(digits()), 24'h002046);

    // Build 261120 = 255*1023 + 255.
    press("clr", 3'b100, 0, 1'b0, 1'b0);
    exp_bin = 0;
    for (int i = 0; i < 255; i++) begin
      exp_bin += 1023;
      press("ramp", 3'b001, exp_bin, 1'b0, 1'b0);
    end
    num = 10'd255;
    press("ramp_last", 3'b001, 261120, 1'b0, 1'b0);
    num = 10'd1023;
    press("to_max", 3'b001, 262143, 1'b0, 1'b0);
    chk("max digits hex", int'(digits()), 24'h262143);
    press("sat", 3'b001, 262143, 1'b1, 1'b0);
    num = 10'd1000;
    press("sub_max", 3'b010, 261143, 1'b0, 1'b0);

    press("clr2", 3'b100, 0, 1'b0, 1'b0);
    num = 10'd5;
    press("add5", 3'b001, 5, 1'b0, 1'b0);
    num = 10'd9;
    press("underflow", 3'b010, 0, 1'b0, 1'b1);
    press("clr_unf", 3'b100, 0, 1'b0, 1'b0);

    num = 10'd5;
    press("add5b", 3'b001, 5, 1'b0, 1'b0);
    num = 10'd7;
    press("add_clr", 3'b101, 0, 1'b0, 1'b0);

    // Subtract pressed while busy must be dropped.
    @(negedge clk);
    btn = 3'b110;
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("drop start", int'(busy), 1);
    btn = 3'b100;
    c = 0;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("drop busy", seen, 0);
    chk("drop bin", int'(bin_18), 7);
    btn = 3'b111;
    repeat (12) @(negedge clk);

    // Bounce shorter than the window produces nothing.
    num = 10'd2;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) btn[0] = ~btn[0];
      @(negedge clk);
      if (busy) seen++;
    end
    btn = 3'b111;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("bounce busy", seen, 0);
    chk("bounce bin", int'(bin_18), 7);
    press("after_bounce", 3'b001, 9, 1'b0, 1'b0);

    // Reset ten cycles into a command.
    num = 10'd3;
    @(negedge clk);
    btn = 3'b110;
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("abort start", int'(busy), 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    btn = 3'b111;
    #1;
    chk("abort bin", int'(bin_18), 0);
    chk("abort digits", int'(digits()), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort flags", int'({ovf, unf}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || digits() != 24'd0 || bin_18 != 18'd0) seen++;
    end
    chk("abort quiet", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
